// File: rtl/wb_port_scheduler_pkg.sv
// Shared definitions for the write-back port scheduler.
// Holds the FSM state encoding, the r0 address constant and the saturating counter helper.
package wb_port_scheduler_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_PEND_B = 1'b1
    } sched_state_e;

    localparam int unsigned R0_ADDR     = 0;
    localparam int unsigned DUAL_CNT_W  = 16;
    localparam logic [DUAL_CNT_W-1:0] DUAL_CNT_MAX = '1;

    function automatic logic [DUAL_CNT_W-1:0] sat_inc(input logic [DUAL_CNT_W-1:0] v);
        return (v == DUAL_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wb_port_scheduler_if.sv
// Request and register-file write signals between write-back and the scheduler.
// The master side issues the A/B write requests; the slave side is the scheduler.
interface wb_port_scheduler_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      reg_a_wr_en_in;
    logic [REG_ADDR_WIDTH-1:0] reg_a_wr_addr_in;
    logic [DATA_WIDTH-1:0]     reg_a_wr_data_in;
    logic                      reg_b_wr_en_in;
    logic [REG_ADDR_WIDTH-1:0] reg_b_wr_addr_in;
    logic [DATA_WIDTH-1:0]     reg_b_wr_data_in;
    logic                      rf_wr_en_out;
    logic [REG_ADDR_WIDTH-1:0] rf_wr_addr_out;
    logic [DATA_WIDTH-1:0]     rf_wr_data_out;
    logic                      stall_out;
    logic [15:0]               dual_wr_count_out;

    modport master (
        output reg_a_wr_en_in, reg_a_wr_addr_in, reg_a_wr_data_in,
        output reg_b_wr_en_in, reg_b_wr_addr_in, reg_b_wr_data_in,
        input  rf_wr_en_out, rf_wr_addr_out, rf_wr_data_out,
        input  stall_out, dual_wr_count_out
    );

    modport slave (
        input  reg_a_wr_en_in, reg_a_wr_addr_in, reg_a_wr_data_in,
        input  reg_b_wr_en_in, reg_b_wr_addr_in, reg_b_wr_data_in,
        output rf_wr_en_out, rf_wr_addr_out, rf_wr_data_out,
        output stall_out, dual_wr_count_out
    );

endinterface

// File: rtl/wb_port_scheduler.sv
// Serializes the primary (A) and HI (B) write-back results onto a single-port register file.
// A dual write to distinct registers stalls the pipeline one cycle and emits A then B.
module wb_port_scheduler
    import wb_port_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_port_scheduler_if.slave bus
);

    // state     | meaning
    // ST_IDLE   | accept new requests from write-back
    // ST_PEND_B | A issued, buffered B goes out next; inputs are a held copy and ignored

    localparam logic [REG_ADDR_WIDTH-1:0] R0 = REG_ADDR_WIDTH'(R0_ADDR);

    sched_state_e              state, state_next;
    logic                      rf_wr_en, rf_wr_en_next;
    logic [REG_ADDR_WIDTH-1:0] rf_wr_addr, rf_wr_addr_next;
    logic [DATA_WIDTH-1:0]     rf_wr_data, rf_wr_data_next;
    logic [REG_ADDR_WIDTH-1:0] pend_addr;
    logic [DATA_WIDTH-1:0]     pend_data;
    logic                      pend_load;
    logic                      cnt_inc;
    logic                      stall_c;
    logic [15:0]               dual_wr_count;
    logic                      a_eff, b_eff;

    assign a_eff = bus.reg_a_wr_en_in && (bus.reg_a_wr_addr_in != R0);
    assign b_eff = bus.reg_b_wr_en_in && (bus.reg_b_wr_addr_in != R0);

    always_comb begin
        state_next      = state;
        rf_wr_en_next   = 1'b0;
        rf_wr_addr_next = rf_wr_addr;
        rf_wr_data_next = rf_wr_data;
        pend_load       = 1'b0;
        cnt_inc         = 1'b0;
        stall_c         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (a_eff && b_eff) begin
                    if (bus.reg_a_wr_addr_in == bus.reg_b_wr_addr_in) begin
                        // Same destination: B is the later write and wins.
                        rf_wr_en_next   = 1'b1;
                        rf_wr_addr_next = bus.reg_b_wr_addr_in;
                        rf_wr_data_next = bus.reg_b_wr_data_in;
                    end else begin
                        rf_wr_en_next   = 1'b1;
                        rf_wr_addr_next = bus.reg_a_wr_addr_in;
                        rf_wr_data_next = bus.reg_a_wr_data_in;
                        pend_load       = 1'b1;
                        cnt_inc         = 1'b1;
                        stall_c         = 1'b1;
                        state_next      = ST_PEND_B;
                    end
                end else if (a_eff) begin
                    rf_wr_en_next   = 1'b1;
                    rf_wr_addr_next = bus.reg_a_wr_addr_in;
                    rf_wr_data_next = bus.reg_a_wr_data_in;
                end else if (b_eff) begin
                    rf_wr_en_next   = 1'b1;
                    rf_wr_addr_next = bus.reg_b_wr_addr_in;
                    rf_wr_data_next = bus.reg_b_wr_data_in;
                end
            end
            ST_PEND_B: begin
                rf_wr_en_next   = 1'b1;
                rf_wr_addr_next = pend_addr;
                rf_wr_data_next = pend_data;
                state_next      = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rf_wr_en      <= 1'b0;
            rf_wr_addr    <= '0;
            rf_wr_data    <= '0;
            pend_addr     <= '0;
            pend_data     <= '0;
            dual_wr_count <= '0;
        end else begin
            state      <= state_next;
            rf_wr_en   <= rf_wr_en_next;
            rf_wr_addr <= rf_wr_addr_next;
            rf_wr_data <= rf_wr_data_next;
            if (pend_load) begin
                pend_addr <= bus.reg_b_wr_addr_in;
                pend_data <= bus.reg_b_wr_data_in;
            end
            if (cnt_inc) begin
                dual_wr_count <= sat_inc(dual_wr_count);
            end
        end
    end

    // Reset must never leak a stall, even if the state register is not yet cleared.
    assign bus.stall_out         = stall_c && rst_n;
    assign bus.rf_wr_en_out      = rf_wr_en;
    assign bus.rf_wr_addr_out    = rf_wr_addr;
    assign bus.rf_wr_data_out    = rf_wr_data;
    assign bus.dual_wr_count_out = dual_wr_count;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Randomized and directed bench for wb_port_scheduler against a queue-based write-order model.
module tb_wb_port_scheduler;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;

    wr_t           pq[$];
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    int            exp_cnt;

    wb_port_scheduler_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus();

    wb_port_scheduler #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic a_en, input logic [AW-1:0] a_addr, input logic [DW-1:0] a_data,
                         input logic b_en, input logic [AW-1:0] b_addr, input logic [DW-1:0] b_data);
        bus.reg_a_wr_en_in   = a_en;
        bus.reg_a_wr_addr_in = a_addr;
        bus.reg_a_wr_data_in = a_data;
        bus.reg_b_wr_en_in   = b_en;
        bus.reg_b_wr_addr_in = b_addr;
        bus.reg_b_wr_data_in = b_data;
    endtask

    // One clock of normal operation: drive, check stall, clock, check registered outputs.
    task automatic step(input string tag,
                        input logic a_en, input logic [AW-1:0] a_addr, input logic [DW-1:0] a_data,
                        input logic b_en, input logic [AW-1:0] b_addr, input logic [DW-1:0] b_data);
        logic exp_stall;
        bit   a_ok, b_ok;
        wr_t  w;
        drive(a_en, a_addr, a_data, b_en, b_addr, b_data);
        exp_stall = 1'b0;
        exp_en    = 1'b0;
        if (pq.size() > 0) begin
            w        = pq.pop_front();
            exp_en   = 1'b1;
            exp_addr = w.addr;
            exp_data = w.data;
        end else begin
            a_ok = a_en && (a_addr != 0);
            b_ok = b_en && (b_addr != 0);
            if (a_ok && b_ok && a_addr != b_addr) begin
                exp_stall = 1'b1;
                exp_en    = 1'b1;
                exp_addr  = a_addr;
                exp_data  = a_data;
                pq.push_back('{addr: b_addr, data: b_data});
                if (exp_cnt < 65535) exp_cnt++;
            end else if (b_ok) begin
                exp_en   = 1'b1;
                exp_addr = b_addr;
                exp_data = b_data;
            end else if (a_ok) begin
                exp_en   = 1'b1;
                exp_addr = a_addr;
                exp_data = a_data;
            end
        end
        #1;
        chk({tag, ".stall"}, 64'(bus.stall_out), 64'(exp_stall));
        @(posedge clk);
        #1;
        chk({tag, ".en"},   64'(bus.rf_wr_en_out),      64'(exp_en));
        chk({tag, ".addr"}, 64'(bus.rf_wr_addr_out),    64'(exp_addr));
        chk({tag, ".data"}, 64'(bus.rf_wr_data_out),    64'(exp_data));
        chk({tag, ".cnt"},  64'(bus.dual_wr_count_out), 64'(exp_cnt));
    endtask

    // One reset clock with a conflicting dual request on the bus.
    task automatic reset_cycle(input string tag);
        rst_n = 1'b0;
        drive(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd4, 32'h2222_2222);
        #1;
        chk({tag, ".stall"}, 64'(bus.stall_out), 64'd0);
        @(posedge clk);
        #1;
        pq.delete();
        exp_en   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_cnt  = 0;
        chk({tag, ".stall_rst"}, 64'(bus.stall_out),         64'd0);
        chk({tag, ".en"},        64'(bus.rf_wr_en_out),      64'd0);
        chk({tag, ".addr"},      64'(bus.rf_wr_addr_out),    64'd0);
        chk({tag, ".data"},      64'(bus.rf_wr_data_out),    64'd0);
        chk({tag, ".cnt"},       64'(bus.dual_wr_count_out), 64'd0);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec    = 0;
        n_fail   = 0;
        exp_en   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_cnt  = 0;
        rst_n    = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        reset_cycle("rst0");
        reset_cycle("rst1");

        step("single_a", 1'b1, 5'd3, 32'h0000_1234, 1'b0, 5'd0, 32'h0);
        step("idle0",    1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 32'h0);

        step("dual_a",   1'b1, 5'd5, 32'hAAAA_0001, 1'b1, 5'd6, 32'hBBBB_0002);
        step("dual_b",   1'b1, 5'd5, 32'hAAAA_0001, 1'b1, 5'd6, 32'hBBBB_0002);
        step("idle1",    1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 32'h0);

        step("same",     1'b1, 5'd7, 32'h1,          1'b1, 5'd7, 32'h2);
        step("r0_a",     1'b1, 5'd0, 32'hFFFF,       1'b1, 5'd9, 32'h42);
        step("r0_both",  1'b1, 5'd0, 32'hx,          1'b1, 5'd0, 32'hx);
        step("x_off",    1'b0, 5'dx, 32'hx,          1'b0, 5'dx, 32'hx);
        step("single_b", 1'b0, 5'd1, 32'h9,          1'b1, 5'd31, 32'hDEAD_BEEF);

        step("rp_dual",  1'b1, 5'd5, 32'h5555_0005, 1'b1, 5'd6, 32'h6666_0006);
        reset_cycle("rst_pend");
        for (int i = 0; i < 3; i++) begin
            step("post_rst", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        end

        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom), 5'($urandom_range(0, 7)), 32'($urandom),
                 1'($urandom), 5'($urandom_range(0, 7)), 32'($urandom));
        end

        // Preload the counter just below saturation instead of issuing 65k dual writes.
        force dut.dual_wr_count = 16'hFFFD;
        #1;
        release dut.dual_wr_count;
        exp_cnt = 65533;
        for (int i = 0; i < 5; i++) begin
            step("sat_a", 1'b1, 5'd10, 32'($urandom), 1'b1, 5'd11, 32'($urandom));
            step("sat_b", 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0);
        end
        chk("sat_final", 64'(bus.dual_wr_count_out), 64'h0000_0000_0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_scheduler.md
WB_PORT_SCHEDULER -- requirements
Module: wb_port_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port reg_a_wr_en_in  input  1  write request, primary result (ALU/mem).
REQ-006 SHALL have port reg_a_wr_addr_in  input  REG_ADDR_WIDTH  primary destination.
REQ-007 SHALL have port reg_a_wr_data_in  input  DATA_WIDTH  primary data.
REQ-008 SHALL have port reg_b_wr_en_in  input  1  write request, HI result.
REQ-009 SHALL have port reg_b_wr_addr_in  input  REG_ADDR_WIDTH  HI destination.
REQ-010 SHALL have port reg_b_wr_data_in  input  DATA_WIDTH  HI data.
REQ-011 SHALL have port rf_wr_en_out  output  1  single-port register file write enable, registered.
REQ-012 SHALL have port rf_wr_addr_out  output  REG_ADDR_WIDTH  write address, registered.
REQ-013 SHALL have port rf_wr_data_out  output  DATA_WIDTH  write data, registered.
REQ-014 SHALL have port stall_out  output  1  combinational; freezes pipeline stages up to and including write-back for one cycle.
REQ-015 SHALL have port dual_wr_count_out  output  16  saturating count of serialized dual writes.

Function
REQ-016 A request is effective only when its enable is 1 and its address is nonzero; writes to r0 SHALL be dropped.
REQ-017 FSM states: IDLE, PEND_B; reset state IDLE.
REQ-018 IDLE, no effective request: next-cycle rf_wr_en_out=0; rf address/data outputs hold their values.
REQ-019 IDLE, exactly one effective request: next cycle rf_wr_en_out=1 with that request's address/data; latency 1; stall_out=0.
REQ-020 IDLE, both effective, addresses equal: only B SHALL be written (later write wins), latency 1, stall_out=0, counter unchanged.
REQ-021 IDLE, both effective, addresses differ: stall_out=1 this cycle; A written next cycle; B address/data captured into pending buffer; state -> PEND_B; counter +1 unless at 0xFFFF.
REQ-022 PEND_B: rf outputs SHALL present buffered B with rf_wr_en_out=1 on the following cycle; stall_out=0; inputs ignored (held copy of already-consumed instruction); state -> IDLE.
REQ-023 Consequence: every dual write costs exactly one stall cycle; outputs A then B on consecutive cycles.
REQ-024 Counter SHALL saturate at 0xFFFF without wrap.
REQ-025 X on a request's data with its enable 0 SHALL NOT affect outputs.

Reset
REQ-026 While rst_n=0 at a clock edge: state=IDLE, rf_wr_en_out=0, rf_wr_addr_out=0, rf_wr_data_out=0, pending buffer=0, dual_wr_count_out=0.
REQ-027 stall_out SHALL be 0 whenever rst_n=0.
REQ-028 Reset in PEND_B SHALL discard the buffered B write; no write occurs after reset release until a new request.

Structure
REQ-029 FSM state encoding and the r0 address constant SHALL live in the shared core defines include, not locally.
REQ-030 Block SHALL be a single module with no sub-modules; it sits between write_back and the register file.

Verification
REQ-031 Single A: a_en=1, a_addr=3, a_data=0x1234, b_en=0 -> next cycle rf_wr_en=1, addr=3, data=0x1234; stall_out=0 throughout.
REQ-032 Dual write: a=(5,0xAAAA0001), b=(6,0xBBBB0002) -> stall_out=1 that cycle; cycle+1 writes (5,0xAAAA0001); cycle+2 writes (6,0xBBBB0002); count=1.
REQ-033 Same address: a=(7,0x1), b=(7,0x2) -> one write (7,0x2) next cycle, no stall, count unchanged.
REQ-034 r0 filtering: a=(0,0xFFFF), b=(9,0x42) -> single write (9,0x42), no stall; a=(0,x), b=(0,x) -> no write.
REQ-035 Reset in PEND_B: dual write (5,..)/(6,..), assert rst_n=0 next edge -> no write of reg 6 ever; all outputs 0; count=0.
REQ-036 Saturation: force 65536 dual writes -> dual_wr_count_out stays 0xFFFF.
